ula_seq_8_bits: RTL and testbench

ULA_SEQ_8_BITS -- requirements
Module: ula_seq_8_bits

---
 rtl/ula_seq_8_bits.sv | 139 +++++++++++++
 tb/tb_ula_seq_8_bits.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ula_seq_8_bits.sv
// Sequencer wrapped around an external 8-bit ALU: accepts a command, drives the
// ALU from registers, captures its result one cycle later and holds it until read.
module ula_seq_8_bits (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_m,
    input  logic [3:0] cmd_s,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    input  logic       cmd_c_in,
    input  logic       cmd_use_acc,
    input  logic       cmd_chain,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_s,
    output logic       alu_m,
    output logic       alu_c_in,
    input  logic [7:0] alu_f,
    input  logic       alu_c_out,
    input  logic       alu_a_eq_b,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_f,
    output logic       res_c_out,
    output logic       res_a_eq_b,
    output logic [7:0] acc,
    output logic       carry,
    output logic [7:0] op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    state_t     state_q, state_d;
    logic [7:0] alu_a_q, alu_a_d;
    logic [7:0] alu_b_q, alu_b_d;
    logic [3:0] alu_s_q, alu_s_d;
    logic       alu_m_q, alu_m_d;
    logic       alu_c_in_q, alu_c_in_d;
    logic [7:0] res_f_q, res_f_d;
    logic       res_c_out_q, res_c_out_d;
    logic       res_a_eq_b_q, res_a_eq_b_d;
    logic [7:0] acc_q, acc_d;
    logic       carry_q, carry_d;
    logic [7:0] op_count_q, op_count_d;

    always_comb begin
        // NOTE: every *_d defaults to its *_q first, so no path leaves a signal
        // unassigned and no latch is inferred; blocking '=' is correct here.
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_s_d      = alu_s_q;
        alu_m_d      = alu_m_q;
        alu_c_in_d   = alu_c_in_q;
        res_f_d      = res_f_q;
        res_c_out_d  = res_c_out_q;
        res_a_eq_b_d = res_a_eq_b_q;
        acc_d        = acc_q;
        carry_d      = carry_q;
        op_count_d   = op_count_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    // acc/carry here are still the previous completed op's values
                    alu_a_d    = cmd_use_acc ? acc_q : cmd_a;
                    alu_b_d    = cmd_b;
                    alu_s_d    = cmd_s;
                    alu_m_d    = cmd_m;
                    alu_c_in_d = cmd_chain ? carry_q : cmd_c_in;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                res_f_d      = alu_f;
                res_c_out_d  = alu_c_out;
                res_a_eq_b_d = alu_a_eq_b;
                acc_d        = alu_f;
                carry_d      = alu_c_out;
                op_count_d   = op_count_q + 8'd1;
                state_d      = HOLD;
            end
            HOLD: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking '<=' so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_s_q      <= '0;
            alu_m_q      <= 1'b0;
            alu_c_in_q   <= 1'b0;
            res_f_q      <= '0;
            res_c_out_q  <= 1'b0;
            res_a_eq_b_q <= 1'b0;
            acc_q        <= '0;
            carry_q      <= 1'b0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_s_q      <= alu_s_d;
            alu_m_q      <= alu_m_d;
            alu_c_in_q   <= alu_c_in_d;
            res_f_q      <= res_f_d;
            res_c_out_q  <= res_c_out_d;
            res_a_eq_b_q <= res_a_eq_b_d;
            acc_q        <= acc_d;
            carry_q      <= carry_d;
            op_count_q   <= op_count_d;
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign res_valid  = (state_q == HOLD);
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_s      = alu_s_q;
    assign alu_m      = alu_m_q;
    assign alu_c_in   = alu_c_in_q;
    assign res_f      = res_f_q;
    assign res_c_out  = res_c_out_q;
    assign res_a_eq_b = res_a_eq_b_q;
    assign acc        = acc_q;
    assign carry      = carry_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_ula_seq_8_bits.sv
// Bench for ula_seq_8_bits with a small behavioural 8-bit ALU closing the loop.
module tb_ula_seq_8_bits;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_m, cmd_c_in, cmd_use_acc, cmd_chain;
    logic [3:0] cmd_s;
    logic [7:0] cmd_a, cmd_b;
    logic [7:0] alu_a, alu_b, alu_f;
    logic [3:0] alu_s;
    logic       alu_m, alu_c_in, alu_c_out, alu_a_eq_b;
    logic       res_valid, res_ready, res_c_out, res_a_eq_b, carry;
    logic [7:0] res_f, acc, op_count;

    int n_pass  = 0;
    int n_total = 0;
    int exp_ops = 0;

    always #5 clk = ~clk;

    ula_seq_8_bits dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_m(cmd_m), .cmd_s(cmd_s),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c_in(cmd_c_in),
        .cmd_use_acc(cmd_use_acc), .cmd_chain(cmd_chain),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_c_in(alu_c_in),
        .alu_f(alu_f), .alu_c_out(alu_c_out), .alu_a_eq_b(alu_a_eq_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_f(res_f),
        .res_c_out(res_c_out), .res_a_eq_b(res_a_eq_b),
        .acc(acc), .carry(carry), .op_count(op_count)
    );

    // Arithmetic: s=0001 A+B+cin, s=0110 A-B-1+cin; logic: 0110 xor, 1011 and, 1110 or.
    always_comb begin
        logic [8:0] sum;
        sum       = 9'd0;
        alu_f     = 8'd0;
        alu_c_out = 1'b0;
        if (!alu_m) begin
            case (alu_s)
                4'b0001: sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_c_in};
                4'b0110: sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'd0, alu_c_in};
                default: sum = {1'b0, alu_a} + {8'd0, alu_c_in};
            endcase
            alu_f     = sum[7:0];
            alu_c_out = sum[8];
        end else begin
            case (alu_s)
                4'b0110: alu_f = alu_a ^ alu_b;
                4'b1011: alu_f = alu_a & alu_b;
                4'b1110: alu_f = alu_a | alu_b;
                default: alu_f = ~alu_a;
            endcase
        end
        alu_a_eq_b = (alu_a == alu_b);
    end

    typedef struct packed {
        logic       m;
        logic [3:0] s;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       use_acc;
        logic       chain;
        logic [7:0] exp_alu_a;
        logic       exp_alu_cin;
        logic [7:0] exp_f;
        logic       exp_c;
        logic       exp_eq;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic drive_cmd(input logic m, input logic [3:0] s, input logic [7:0] a,
                             input logic [7:0] b, input logic cin, input logic ua, input logic ch);
        cmd_valid = 1'b1; cmd_m = m; cmd_s = s; cmd_a = a; cmd_b = b;
        cmd_c_in = cin; cmd_use_acc = ua; cmd_chain = ch;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        drive_cmd(v.m, v.s, v.a, v.b, v.cin, v.use_acc, v.chain);
        check($sformatf("v%0d ready_before", i), {31'd0, cmd_ready}, 32'd1);
        @(posedge clk); #1;
        check($sformatf("v%0d ready_exec", i), {31'd0, cmd_ready}, 32'd0);
        check($sformatf("v%0d valid_exec", i), {31'd0, res_valid}, 32'd0);
        check($sformatf("v%0d alu_a", i), {24'd0, alu_a}, {24'd0, v.exp_alu_a});
        check($sformatf("v%0d alu_b", i), {24'd0, alu_b}, {24'd0, v.b});
        check($sformatf("v%0d alu_s_m", i), {27'd0, alu_m, alu_s}, {27'd0, v.m, v.s});
        check($sformatf("v%0d alu_c_in", i), {31'd0, alu_c_in}, {31'd0, v.exp_alu_cin});
        cmd_valid = 1'b0; cmd_a = ~v.a; cmd_c_in = ~v.cin;
        @(posedge clk); #1;
        exp_ops = (exp_ops + 1) % 256;
        check($sformatf("v%0d valid_hold", i), {31'd0, res_valid}, 32'd1);
        check($sformatf("v%0d res_f", i), {24'd0, res_f}, {24'd0, v.exp_f});
        check($sformatf("v%0d res_c_eq", i), {30'd0, res_c_out, res_a_eq_b}, {30'd0, v.exp_c, v.exp_eq});
        check($sformatf("v%0d acc_carry", i), {23'd0, acc, carry}, {23'd0, v.exp_f, v.exp_c});
        check($sformatf("v%0d op_count", i), {24'd0, op_count}, exp_ops);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check($sformatf("v%0d back_idle", i), {30'd0, res_valid, cmd_ready}, 32'd1);
    endtask

    task automatic quick_op();
        drive_cmd(1'b0, 4'b0001, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        cmd_valid = 1'b0; res_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    initial begin
        //               m  s        a      b      cin ua ch exp_a  cin  f      c  eq
        vecs[0] = '{1'b0, 4'b0001, 8'h3F, 8'h0A, 1'b0, 1'b0, 1'b0, 8'h3F, 1'b0, 8'h49, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 4'b0001, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 4'b0001, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'h01, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 4'b0001, 8'h10, 8'h05, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0, 8'h15, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 4'b0001, 8'h77, 8'h05, 1'b0, 1'b1, 1'b0, 8'h15, 1'b0, 8'h1A, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 4'b0110, 8'hAA, 8'hAA, 1'b0, 1'b0, 1'b0, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 4'b0110, 8'hF0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'hF0, 1'b0, 8'hCC, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 4'b1011, 8'hF0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'hF0, 1'b0, 8'h30, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 4'b0001, 8'h80, 8'h80, 1'b1, 1'b0, 1'b0, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1};
        vecs[9] = '{1'b0, 4'b0001, 8'h01, 8'h01, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 8'h03, 1'b0, 1'b1};

        rst = 1'b0; cmd_valid = 1'b0; cmd_m = 1'b0; cmd_s = 4'd0; cmd_a = 8'd0; cmd_b = 8'd0;
        cmd_c_in = 1'b0; cmd_use_acc = 1'b0; cmd_chain = 1'b0; res_ready = 1'b0;

        // Asynchronous reset, checked before any clock edge
        #1 rst = 1'b1;
        #1;
        check("rst ready", {31'd0, cmd_ready}, 32'd1);
        check("rst valid", {31'd0, res_valid}, 32'd0);
        check("rst alu", {7'd0, alu_a, alu_b, alu_s, alu_m, alu_c_in}, 32'd0);
        check("rst res", {22'd0, res_f, res_c_out, res_a_eq_b}, 32'd0);
        check("rst state", {15'd0, acc, carry, op_count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(i);

        // Idle without cmd_valid: alu_* hold
        cmd_valid = 1'b0; cmd_a = 8'h5A; cmd_b = 8'hA5;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("idle hold alu", {16'd0, alu_a, alu_b}, {16'd0, 8'h01, 8'h01});
        check("idle ready", {30'd0, res_valid, cmd_ready}, 32'd1);

        // res_ready high through EXEC is ignored; result still presented
        drive_cmd(1'b0, 4'b0001, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);
        res_ready = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("early_rdy exec valid", {31'd0, res_valid}, 32'd0);
        @(posedge clk); #1;
        exp_ops++;
        check("early_rdy hold", {23'd0, res_valid, res_f}, {23'd0, 1'b1, 8'h03});
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("early_rdy idle", {30'd0, res_valid, cmd_ready}, 32'd1);

        // Backpressure: stalled in HOLD with a pending command
        drive_cmd(1'b0, 4'b0001, 8'h20, 8'h22, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive_cmd(1'b0, 4'b0001, 8'h99, 8'h01, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        exp_ops++;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d valid_ready", k), {30'd0, res_valid, cmd_ready}, 32'd2);
            check($sformatf("bp%0d res_f", k), {24'd0, res_f}, 32'h42);
            check($sformatf("bp%0d alu_a", k), {24'd0, alu_a}, 32'h20);
            check($sformatf("bp%0d op_count", k), {24'd0, op_count}, exp_ops);
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("bp release idle", {30'd0, res_valid, cmd_ready}, 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("bp next accept", {23'd0, cmd_ready, alu_a}, {23'd0, 1'b0, 8'h99});
        @(posedge clk); #1;
        exp_ops++;
        check("bp next res", {23'd0, res_valid, res_f}, {23'd0, 1'b1, 8'h9A});
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;

        // Reset during EXEC discards the op
        drive_cmd(1'b0, 4'b0001, 8'h11, 8'h11, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("mid exec ready", {31'd0, cmd_ready}, 32'd0);
        rst = 1'b1;
        #1;
        check("mid rst ready_valid", {30'd0, res_valid, cmd_ready}, 32'd1);
        check("mid rst state", {15'd0, acc, carry, op_count}, 32'd0);
        check("mid rst alu_a", {24'd0, alu_a}, 32'd0);
        #1 rst = 1'b0;
        exp_ops = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("post rst no result", {15'd0, res_valid, op_count, acc}, 32'd0);

        // Rst released mid-cycle; first command accepted on the first edge
        rst = 1'b1;
        #2 rst = 1'b0;
        drive_cmd(1'b0, 4'b0001, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("first after rst", {23'd0, cmd_ready, alu_a}, {23'd0, 1'b0, 8'h01});
        res_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        res_ready = 1'b0;

        // op_count wrap: 256 ops since reset return it to 00
        for (int k = 0; k < 254; k++) quick_op();
        check("count 255", {24'd0, op_count}, 32'hFF);
        quick_op();
        check("count wrap", {24'd0, op_count}, 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
